// File: rtl/mult_div_unit.sv
// Iterative multiply/divide unit holding the architectural HI/LO pair.
// Ports: CLK, RST (sync, active-high), start, op[2:0], in_rs, in_rt ->
//        busy, done, div_by_zero, hi, lo.
module mult_div_unit #(
    parameter int WIDTH = 32
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] in_rs,
    input  logic [WIDTH-1:0] in_rt,
    output logic             busy,
    output logic             done,
    output logic             div_by_zero,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DIV  = 2'd2,
        FIX  = 2'd3
    } state_t;

    state_t             state_q, state_d;
    logic [2*WIDTH-1:0] acc_q, acc_d;
    logic [WIDTH-1:0]   opb_q, opb_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic               mul_q, mul_d;
    logic               neg_lo_q, neg_lo_d;
    logic               neg_hi_q, neg_hi_d;
    logic               dbz_q, dbz_d;
    logic [WIDTH-1:0]   hi_q, hi_d;
    logic [WIDTH-1:0]   lo_q, lo_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               dz_out_q, dz_out_d;

    // Signed variants have op[0] clear; magnitudes go into the datapath.
    logic               sgn;
    logic               a_neg;
    logic               b_neg;
    logic [WIDTH-1:0]   abs_a;
    logic [WIDTH-1:0]   abs_b;

    assign sgn   = ~op[0];
    assign a_neg = sgn & in_rs[WIDTH-1];
    assign b_neg = sgn & in_rt[WIDTH-1];
    assign abs_a = a_neg ? (~in_rs + 1'b1) : in_rs;
    assign abs_b = b_neg ? (~in_rt + 1'b1) : in_rt;

    // Shift-add step: acc = {partial product, remaining multiplier bits}.
    logic [WIDTH:0]     mul_sum;
    assign mul_sum = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
                   + (acc_q[0] ? {1'b0, opb_q} : {(WIDTH+1){1'b0}});

    // Restoring step: acc = {partial remainder, dividend/quotient bits}.
    logic [WIDTH:0]     div_shift;
    logic [WIDTH:0]     div_diff;
    logic               div_ok;
    assign div_shift = acc_q[2*WIDTH-1:WIDTH-1];
    assign div_diff  = div_shift - {1'b0, opb_q};
    assign div_ok    = ~div_diff[WIDTH];

    // Sign fix-up values used in FIX.
    logic [2*WIDTH-1:0] prod;
    logic [WIDTH-1:0]   quo;
    logic [WIDTH-1:0]   rem;
    assign prod = neg_lo_q ? (~acc_q + 1'b1) : acc_q;
    assign quo  = neg_lo_q ? (~acc_q[WIDTH-1:0] + 1'b1)
                           : acc_q[WIDTH-1:0];
    assign rem  = neg_hi_q ? (~acc_q[2*WIDTH-1:WIDTH] + 1'b1)
                           : acc_q[2*WIDTH-1:WIDTH];

    always_comb begin
        state_d  = state_q;
        acc_d    = acc_q;
        opb_d    = opb_q;
        cnt_d    = cnt_q;
        mul_d    = mul_q;
        neg_lo_d = neg_lo_q;
        neg_hi_d = neg_hi_q;
        dbz_d    = dbz_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        done_d   = 1'b0;
        dz_out_d = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (start) begin
                    case (op)
                        3'b000, 3'b001: begin
                            state_d  = MUL;
                            acc_d    = {{WIDTH{1'b0}}, abs_b};
                            opb_d    = abs_a;
                            cnt_d    = CW'(WIDTH - 1);
                            mul_d    = 1'b1;
                            neg_lo_d = a_neg ^ b_neg;
                            neg_hi_d = a_neg ^ b_neg;
                            dbz_d    = 1'b0;
                        end
                        3'b010, 3'b011: begin
                            state_d  = DIV;
                            acc_d    = {{WIDTH{1'b0}}, abs_a};
                            opb_d    = abs_b;
                            cnt_d    = CW'(WIDTH - 1);
                            mul_d    = 1'b0;
                            neg_lo_d = a_neg ^ b_neg;
                            neg_hi_d = a_neg;
                            dbz_d    = (in_rt == '0);
                        end
                        3'b100:  hi_d = in_rs;
                        3'b101:  lo_d = in_rs;
                        default: ;
                    endcase
                end
            end
            MUL: begin
                acc_d = {mul_sum, acc_q[WIDTH-1:1]};
                if (cnt_q == '0) state_d = FIX;
                else             cnt_d   = cnt_q - 1'b1;
            end
            DIV: begin
                acc_d = {div_ok ? div_diff[WIDTH-1:0]
                                : div_shift[WIDTH-1:0],
                         acc_q[WIDTH-2:0], div_ok};
                if (cnt_q == '0) state_d = FIX;
                else             cnt_d   = cnt_q - 1'b1;
            end
            FIX: begin
                state_d = IDLE;
                done_d  = 1'b1;
                if (mul_q) begin
                    hi_d = prod[2*WIDTH-1:WIDTH];
                    lo_d = prod[WIDTH-1:0];
                end else begin
                    // Zero divisor leaves |A| as remainder; re-signing
                    // it restores the original dividend.
                    lo_d     = dbz_q ? {WIDTH{1'b1}} : quo;
                    hi_d     = rem;
                    dz_out_d = dbz_q;
                end
            end
        endcase

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q  <= IDLE;
            acc_q    <= '0;
            opb_q    <= '0;
            cnt_q    <= '0;
            mul_q    <= 1'b0;
            neg_lo_q <= 1'b0;
            neg_hi_q <= 1'b0;
            dbz_q    <= 1'b0;
            hi_q     <= '0;
            lo_q     <= '0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            dz_out_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            acc_q    <= acc_d;
            opb_q    <= opb_d;
            cnt_q    <= cnt_d;
            mul_q    <= mul_d;
            neg_lo_q <= neg_lo_d;
            neg_hi_q <= neg_hi_d;
            dbz_q    <= dbz_d;
            hi_q     <= hi_d;
            lo_q     <= lo_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            dz_out_q <= dz_out_d;
        end
    end

    assign busy        = busy_q;
    assign done        = done_q;
    assign div_by_zero = dz_out_q;
    assign hi          = hi_q;
    assign lo          = lo_q;

endmodule
